// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code lock: key map, state/tone enums,
// display glyph nibbles and the keypad decoder.
package code_lock_pkg;

    localparam logic [15:0] KEY_0      = 16'h0008;
    localparam logic [15:0] KEY_1      = 16'h0080;
    localparam logic [15:0] KEY_2      = 16'h0040;
    localparam logic [15:0] KEY_3      = 16'h0020;
    localparam logic [15:0] KEY_4      = 16'h0800;
    localparam logic [15:0] KEY_5      = 16'h0400;
    localparam logic [15:0] KEY_6      = 16'h0200;
    localparam logic [15:0] KEY_7      = 16'h8000;
    localparam logic [15:0] KEY_8      = 16'h4000;
    localparam logic [15:0] KEY_9      = 16'h2000;
    localparam logic [15:0] KEY_ENTER  = 16'h0001;
    localparam logic [15:0] KEY_CLEAR  = 16'h1000;
    localparam logic [15:0] KEY_MASTER = 16'h0100;

    localparam logic [3:0] NIB_BLANK = 4'hF;
    localparam logic [3:0] NIB_PASS  = 4'hA;
    localparam logic [3:0] NIB_LOCK  = 4'h0;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_PASS,
        ST_LOCKOUT
    } lock_state_t;

    typedef enum logic [1:0] {
        TONE_NONE,
        TONE_CLICK,
        TONE_PASS,
        TONE_FAIL
    } tone_kind_t;

    typedef enum logic [1:0] {
        EV_DIGIT,
        EV_ENTER,
        EV_CLEAR,
        EV_MASTER
    } key_kind_t;

    typedef struct packed {
        logic      valid;
        key_kind_t kind;
        logic [3:0] digit;
    } key_event_t;

    // Anything that is not exactly one mapped key (idle, multi-hot, unused) is invalid.
    function automatic key_event_t decode_key(input logic [15:0] bus);
        key_event_t ev;
        ev.valid = 1'b1;
        ev.kind  = EV_DIGIT;
        ev.digit = 4'd0;
        case (bus)
            KEY_0:      ev.digit = 4'd0;
            KEY_1:      ev.digit = 4'd1;
            KEY_2:      ev.digit = 4'd2;
            KEY_3:      ev.digit = 4'd3;
            KEY_4:      ev.digit = 4'd4;
            KEY_5:      ev.digit = 4'd5;
            KEY_6:      ev.digit = 4'd6;
            KEY_7:      ev.digit = 4'd7;
            KEY_8:      ev.digit = 4'd8;
            KEY_9:      ev.digit = 4'd9;
            KEY_ENTER:  ev.kind  = EV_ENTER;
            KEY_CLEAR:  ev.kind  = EV_CLEAR;
            KEY_MASTER: ev.kind  = EV_MASTER;
            default:    ev.valid = 1'b0;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/lock_tone_gen.sv
// Pattern buzzer: a request pulse restarts the selected tone from its first
// edge; duration and half-period counters are sized from CLK_HZ.
module lock_tone_gen
    import code_lock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  tone_kind_t req,
    output logic       buzzer
);

    localparam int unsigned CLICK_LEN  = CLK_HZ / 5;
    localparam int unsigned PASS_LEN   = (CLK_HZ * 3) / 5;
    localparam int unsigned FAIL_SEG   = CLK_HZ / 10;
    localparam int unsigned FAIL_LEN   = 3 * FAIL_SEG;
    localparam int unsigned CLICK_HALF = CLK_HZ / 1000;
    localparam int unsigned PASS_HALF  = CLK_HZ / 2000;
    localparam int unsigned FAIL_HALF  = CLK_HZ / 500;

    localparam int unsigned DUR_W  = $clog2(PASS_LEN + 1);
    localparam int unsigned HALF_W = $clog2(FAIL_HALF + 1);

    localparam logic [DUR_W-1:0]  CLICK_END  = DUR_W'(CLICK_LEN - 1);
    localparam logic [DUR_W-1:0]  PASS_END   = DUR_W'(PASS_LEN - 1);
    localparam logic [DUR_W-1:0]  FAIL_END   = DUR_W'(FAIL_LEN - 1);
    localparam logic [DUR_W-1:0]  GAP_LO     = DUR_W'(FAIL_SEG);
    localparam logic [DUR_W-1:0]  GAP_HI     = DUR_W'(2 * FAIL_SEG);
    localparam logic [HALF_W-1:0] CLICK_HEND = HALF_W'(CLICK_HALF - 1);
    localparam logic [HALF_W-1:0] PASS_HEND  = HALF_W'(PASS_HALF - 1);
    localparam logic [HALF_W-1:0] FAIL_HEND  = HALF_W'(FAIL_HALF - 1);

    tone_kind_t        kind;
    logic [DUR_W-1:0]  dur_cnt;
    logic [HALF_W-1:0] half_cnt;
    logic              sq;
    logic [DUR_W-1:0]  dur_end;
    logic [HALF_W-1:0] half_end;
    logic              in_gap;

    always_comb begin
        dur_end  = CLICK_END;
        half_end = CLICK_HEND;
        case (kind)
            TONE_PASS: begin
                dur_end  = PASS_END;
                half_end = PASS_HEND;
            end
            TONE_FAIL: begin
                dur_end  = FAIL_END;
                half_end = FAIL_HEND;
            end
            default: ;
        endcase
        in_gap = (kind == TONE_FAIL) && (dur_cnt >= GAP_LO) && (dur_cnt < GAP_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind     <= TONE_NONE;
            dur_cnt  <= '0;
            half_cnt <= '0;
            sq       <= 1'b0;
        end else if (req != TONE_NONE) begin
            kind     <= req;
            dur_cnt  <= '0;
            half_cnt <= '0;
            sq       <= 1'b1;
        end else if (kind != TONE_NONE) begin
            if (dur_cnt == dur_end) begin
                kind     <= TONE_NONE;
                dur_cnt  <= '0;
                half_cnt <= '0;
                sq       <= 1'b0;
            end else begin
                dur_cnt <= dur_cnt + 1'b1;
                if (half_cnt == half_end) begin
                    half_cnt <= '0;
                    sq       <= ~sq;
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end
        end
    end

    // The square wave keeps running through the fail gap so the third burst stays phase-aligned.
    assign buzzer = sq && !in_gap;

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: edge-detects keypad events, assembles and checks the code,
// counts failed tries with lockout. Buzzer present only with LOCK_TONE_EN defined.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned MAX_TRIES = 6,
    parameter int unsigned CLK_HZ    = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  key_onehot,
    input  logic [4*DIGITS-1:0]          secret,
    output logic [4*DIGITS-1:0]          disp,
    output logic [$clog2(DIGITS+1)-1:0]  entered,
    output logic [3:0]                   tries,
    output logic                         unlocked,
    output logic                         locked,
    output logic                         buzzer
);

    localparam int unsigned EW = $clog2(DIGITS + 1);
    localparam logic [EW-1:0] FULL      = EW'(DIGITS);
    localparam logic [3:0]    TRY_LIMIT = 4'(MAX_TRIES);

    lock_state_t         state, state_n;
    logic [15:0]         key_prev;
    key_event_t          ev_now, ev_q;
    logic [4*DIGITS-1:0] disp_n;
    logic [EW-1:0]       entered_n;
    logic [3:0]          tries_n, tries_inc;
    tone_kind_t          tone_req;

    // Only a press from an idle bus counts; held or released keys produce nothing.
    always_comb begin
        ev_now = decode_key(key_onehot);
        if (key_prev != '0) ev_now.valid = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev <= '0;
            ev_q     <= '0;
            state    <= ST_ENTRY;
            disp     <= {DIGITS{NIB_BLANK}};
            entered  <= '0;
            tries    <= '0;
        end else begin
            key_prev <= key_onehot;
            ev_q     <= ev_now;
            state    <= state_n;
            disp     <= disp_n;
            entered  <= entered_n;
            tries    <= tries_n;
        end
    end

    always_comb begin
        state_n   = state;
        disp_n    = disp;
        entered_n = entered;
        tries_n   = tries;
        tone_req  = TONE_NONE;
        tries_inc = tries + 4'd1;
        if (ev_q.valid) begin
            if (ev_q.kind == EV_MASTER) begin
                state_n   = ST_ENTRY;
                disp_n    = {DIGITS{NIB_BLANK}};
                entered_n = '0;
                tries_n   = '0;
            end else if (ev_q.kind == EV_CLEAR) begin
                if (state != ST_LOCKOUT) begin
                    state_n   = ST_ENTRY;
                    disp_n    = {DIGITS{NIB_BLANK}};
                    entered_n = '0;
                end
            end else if (state == ST_ENTRY) begin
                if (ev_q.kind == EV_DIGIT) begin
                    tone_req = TONE_CLICK;
                    if (entered != FULL) begin
                        disp_n    = (disp << 4) | (4*DIGITS)'(ev_q.digit);
                        entered_n = entered + 1'b1;
                    end
                end else if (entered == FULL) begin
                    if (disp == secret) begin
                        state_n  = ST_PASS;
                        disp_n   = {DIGITS{NIB_PASS}};
                        tone_req = TONE_PASS;
                    end else begin
                        tries_n   = tries_inc;
                        entered_n = '0;
                        tone_req  = TONE_FAIL;
                        if (tries_inc == TRY_LIMIT) begin
                            state_n = ST_LOCKOUT;
                            disp_n  = {DIGITS{NIB_LOCK}};
                        end else begin
                            disp_n  = {DIGITS{NIB_BLANK}};
                        end
                    end
                end
            end
        end
    end

    assign unlocked = (state == ST_PASS);
    assign locked   = (state == ST_LOCKOUT);

`ifdef LOCK_TONE_EN
    lock_tone_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tone (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (tone_req),
        .buzzer (buzzer)
    );
`else
    logic [1:0] unused_tone_req;
    assign unused_tone_req = tone_req;
    assign buzzer          = 1'b0;
`endif

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised keypad code-lock controller: takes the one-hot key bus from the 4x4 keypad scanner, assembles a DIGITS-long code, compares it with a secret on ENTER, counts failed tries with lockout, and drives the nibble display bus and a pattern buzzer. It replaces the fixed 3-digit lock and sits between the keypad scanner and the 7-segment display decoder.

## Interface
- DIGITS, 3, code length in decimal digits (1..8)
- MAX_TRIES, 6, failed attempts before lockout (1..15)
- CLK_HZ, 50_000_000, clk frequency; all tone/duration counts derive from it
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous and active-low
- key_onehot  in  16  keypad scanner bus, held while key pressed, 0 when idle
- secret  in  4*DIGITS  expected code, BCD, digit 0 in [3:0]; sampled on ENTER
- disp  out  4*DIGITS  display nibbles, newest digit in [3:0]; 4'hF = blank
- entered  out  $clog2(DIGITS+1)  digits currently entered
- tries  out  4  failed attempts since last master clear
- unlocked  out  1  high in PASS
- locked  out  1  high in LOCKOUT
- buzzer  out  1  square-wave buzzer drive

## Operation
- Key map: 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9, 0x0001=ENTER, 0x1000=CLEAR, 0x0100=MASTER; any other value, including multi-hot, ignored.
- Key event: registered previous bus; event only when previous==0 and current is a mapped one-hot value. Held keys give one event; release gives none.
- States: ENTRY, PASS, LOCKOUT.
- ENTRY, digit: if entered<DIGITS, disp shifts left one nibble, new digit into [3:0], entered+1; at entered==DIGITS digit dropped. Click tone either way.
- ENTRY, ENTER with entered<DIGITS: ignored, no tone.
- ENTRY, ENTER with entered==DIGITS: disp==secret -> PASS, disp all 4'hA (PASS glyph), pass tone. Else tries+1, disp all blank, entered=0, fail tone; if new tries==MAX_TRIES -> LOCKOUT, disp all 4'h0.
- CLEAR: in ENTRY/PASS -> ENTRY, disp blank, entered=0, tries kept. Ignored in LOCKOUT.
- MASTER: any state -> ENTRY, disp blank, entered=0, tries=0.
- PASS and LOCKOUT ignore digits and ENTER.
- Tones: click 1/5 s at 500 Hz; pass 3/5 s at 1 kHz; fail 1/10 s on, 1/10 s off, 1/10 s on at 250 Hz. New request aborts any running tone and restarts; pass/fail outrank click in the same cycle. buzzer low when idle.

## Timing
- Reset values: disp all 4'hF, entered 0, tries 0, unlocked 0, locked 0, buzzer 0, state ENTRY, tone idle.
- Key bus sampled at edge N; all resulting output updates visible after edge N+1 (one-cycle latency, registered outputs).
- buzzer goes high the same edge the tone starts; toggles every CLK_HZ/(2*f) cycles; tone length counted from start edge.
- rst_n asserted mid-tone or mid-entry: immediate return to reset values, no completion of pattern.
- Counter widths derived with $clog2 from CLK_HZ; no wrap of tries beyond MAX_TRIES.

## Configuration
- LOCK_TONE_EN: defined -> tone generator instantiated, behaviour above. Undefined -> buzzer tied 0, no tone counters synthesised; all other behaviour unchanged.

## Structure
- Package code_lock_pkg: key one-hot constants, state enum, BLANK/PASS/LOCK nibble constants, tone-kind enum (NONE, CLICK, PASS, FAIL).
- Sub-module lock_tone_gen: takes tone-kind request pulse, produces buzzer; holds duration and half-period counters.

## Test plan (CLK_HZ=10_000, DIGITS=3, MAX_TRIES=6)
- Press 2,4,6 (secret 0x246) then ENTER -> disp 0x246 before ENTER, then 0xAAA, unlocked=1, 1 kHz burst of 6000 cycles.
- Hold key 5 for 100 cycles -> exactly one digit, entered=1, one 2000-cycle click.
- Wrong code 1,2,3,ENTER six times -> tries 1..6, blank after each, on sixth locked=1, disp 0x000; digits ignored; MASTER -> ENTRY, tries=0.
- Press 1,2,3,4 -> disp 0x123, entered=3; ENTER after only 1,2 -> no change, no tone.
- Digit pressed during pass tone -> digit ignored in PASS; CLEAR -> ENTRY blank, tries unchanged, click aborts nothing (CLEAR has no tone).
- rst_n low mid fail tone -> buzzer 0 and all reset values next sample; multi-hot 0x0009 -> no event.
